// File: rtl/flg_offset_gen_if.sv
// Flag-block in / match-beat out stream bundle for flg_offset_gen.
// master drives blocks and consumes beats; slave is the scheduler.
interface flg_offset_gen_if #(
   parameter int FLG_WIDTH = 32
);
   localparam int OFS_WIDTH = $clog2(FLG_WIDTH) + 1;

   logic                 in_vld;
   logic                 in_rdy;
   logic [FLG_WIDTH-1:0] in_flg_act;
   logic [FLG_WIDTH-1:0] in_flg_wei;
   logic                 out_vld;
   logic                 out_rdy;
   logic [OFS_WIDTH-1:0] out_ofs_act;
   logic [OFS_WIDTH-1:0] out_ofs_wei;
   logic [OFS_WIDTH-1:0] out_pos;
   logic                 out_last;
   logic                 out_empty;

   modport master (
      output in_vld, in_flg_act, in_flg_wei, out_rdy,
      input  in_rdy, out_vld, out_ofs_act, out_ofs_wei,
      input  out_pos, out_last, out_empty
   );

   modport slave (
      input  in_vld, in_flg_act, in_flg_wei, out_rdy,
      output in_rdy, out_vld, out_ofs_act, out_ofs_wei,
      output out_pos, out_last, out_empty
   );
endinterface

// File: rtl/flg_offset_gen.sv
// Sparsity-match scheduler: walks act&wei one set bit per cycle and
// emits packed-array offsets for the MAC datapath.
module flg_offset_gen #(
   parameter int FLG_WIDTH      = 32,
   parameter bit SCAN_MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   flg_offset_gen_if.slave  bus
);
   localparam int OFS_WIDTH = $clog2(FLG_WIDTH) + 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t               r_state, w_state_nxt;
   logic [FLG_WIDTH-1:0] r_act, r_wei, r_match;
   logic [FLG_WIDTH-1:0] w_act_nxt, w_wei_nxt, w_match_nxt;
   logic [FLG_WIDTH-1:0] w_rem;
   logic                 r_vld, r_last, r_empty;
   logic                 w_vld_nxt, w_last_nxt, w_empty_nxt;
   logic [OFS_WIDTH-1:0] r_ofs_act, r_ofs_wei, r_pos;
   logic [OFS_WIDTH-1:0] w_ofs_act_nxt, w_ofs_wei_nxt, w_pos_nxt;
   logic                 w_found;
   logic [OFS_WIDTH-1:0] w_pos, w_oa, w_ow;
   logic [OFS_WIDTH-1:0] w_cnt_act, w_cnt_wei;
   logic                 w_free, w_acc;

   function automatic int scan_idx(input int k);
      return SCAN_MSB_FIRST ? FLG_WIDTH - 1 - k : k;
   endfunction

   assign bus.in_rdy      = (r_state == IDLE) & ~flush & rst_n;
   assign bus.out_vld     = r_vld;
   assign bus.out_ofs_act = r_ofs_act;
   assign bus.out_ofs_wei = r_ofs_wei;
   assign bus.out_pos     = r_pos;
   assign bus.out_last    = r_last;
   assign bus.out_empty   = r_empty;

   assign w_free = ~r_vld | bus.out_rdy;
   assign w_acc  = bus.in_vld & bus.in_rdy;

   // Offsets count the full captured flags ahead of the first remaining match.
   always_comb begin
      w_found   = 1'b0;
      w_pos     = '0;
      w_oa      = '0;
      w_ow      = '0;
      w_cnt_act = '0;
      w_cnt_wei = '0;
      w_rem     = r_match;
      for (int k = 0; k < FLG_WIDTH; k++) begin
         if (!w_found && r_match[scan_idx(k)]) begin
            w_found               = 1'b1;
            w_pos                 = OFS_WIDTH'(scan_idx(k));
            w_oa                  = w_cnt_act;
            w_ow                  = w_cnt_wei;
            w_rem[scan_idx(k)]    = 1'b0;
         end
         if (!w_found) begin
            w_cnt_act = w_cnt_act + OFS_WIDTH'(r_act[scan_idx(k)]);
            w_cnt_wei = w_cnt_wei + OFS_WIDTH'(r_wei[scan_idx(k)]);
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_act_nxt     = r_act;
      w_wei_nxt     = r_wei;
      w_match_nxt   = r_match;
      w_vld_nxt     = r_vld;
      w_last_nxt    = r_last;
      w_empty_nxt   = r_empty;
      w_ofs_act_nxt = r_ofs_act;
      w_ofs_wei_nxt = r_ofs_wei;
      w_pos_nxt     = r_pos;
      if (flush) begin
         w_state_nxt   = IDLE;
         w_match_nxt   = '0;
         w_vld_nxt     = 1'b0;
         w_last_nxt    = 1'b0;
         w_empty_nxt   = 1'b0;
         w_ofs_act_nxt = '0;
         w_ofs_wei_nxt = '0;
         w_pos_nxt     = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_free) w_vld_nxt = 1'b0;
               if (w_acc) begin
                  w_act_nxt   = bus.in_flg_act;
                  w_wei_nxt   = bus.in_flg_wei;
                  w_match_nxt = bus.in_flg_act & bus.in_flg_wei;
                  w_state_nxt = SCAN;
               end
            end
            SCAN: begin
               if (w_free) begin
                  w_vld_nxt = 1'b1;
                  if (w_found) begin
                     w_pos_nxt     = w_pos;
                     w_ofs_act_nxt = w_oa;
                     w_ofs_wei_nxt = w_ow;
                     w_match_nxt   = w_rem;
                     w_last_nxt    = (w_rem == '0);
                     w_empty_nxt   = 1'b0;
                     if (w_rem == '0) w_state_nxt = IDLE;
                  end else begin
                     w_pos_nxt     = '0;
                     w_ofs_act_nxt = '0;
                     w_ofs_wei_nxt = '0;
                     w_last_nxt    = 1'b1;
                     w_empty_nxt   = 1'b1;
                     w_state_nxt   = IDLE;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_act     <= '0;
         r_wei     <= '0;
         r_match   <= '0;
         r_vld     <= 1'b0;
         r_last    <= 1'b0;
         r_empty   <= 1'b0;
         r_ofs_act <= '0;
         r_ofs_wei <= '0;
         r_pos     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_act     <= w_act_nxt;
         r_wei     <= w_wei_nxt;
         r_match   <= w_match_nxt;
         r_vld     <= w_vld_nxt;
         r_last    <= w_last_nxt;
         r_empty   <= w_empty_nxt;
         r_ofs_act <= w_ofs_act_nxt;
         r_ofs_wei <= w_ofs_wei_nxt;
         r_pos     <= w_pos_nxt;
      end
   end
endmodule

// File: tb/tb_flg_offset_gen.sv
// Bench: LSB-first and MSB-first 8-bit schedulers share one stimulus
// stream and are checked every cycle against a queue-based model.
module tb_flg_offset_gen;
   localparam int W = 8;

   typedef struct packed {
      logic [3:0] pos;
      logic [3:0] oa;
      logic [3:0] ow;
      logic       last;
      logic       empty;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_vld = 1'b0;
   logic       out_rdy = 1'b0;
   logic [7:0] act = '0;
   logic [7:0] wei = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flg_offset_gen_if #(.FLG_WIDTH(W)) ifl ();
   flg_offset_gen_if #(.FLG_WIDTH(W)) ifm ();

   assign ifl.in_vld     = in_vld;
   assign ifl.in_flg_act = act;
   assign ifl.in_flg_wei = wei;
   assign ifl.out_rdy    = out_rdy;
   assign ifm.in_vld     = in_vld;
   assign ifm.in_flg_act = act;
   assign ifm.in_flg_wei = wei;
   assign ifm.out_rdy    = out_rdy;

   flg_offset_gen #(.FLG_WIDTH(W), .SCAN_MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifl.slave)
   );
   flg_offset_gen #(.FLG_WIDTH(W), .SCAN_MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifm.slave)
   );

   function automatic void chk(input string nm, input logic [31:0] got,
                               input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endfunction

   function automatic beat_t beat_l();
      return {ifl.out_pos, ifl.out_ofs_act, ifl.out_ofs_wei,
              ifl.out_last, ifl.out_empty};
   endfunction

   function automatic beat_t beat_m();
      return {ifm.out_pos, ifm.out_ofs_act, ifm.out_ofs_wei,
              ifm.out_last, ifm.out_empty};
   endfunction

   // Reference: list every beat a block produces, straight from the rules.
   beat_t bq[$];
   function automatic void build(input logic [7:0] a, input logic [7:0] w,
                                 input bit msb);
      logic [7:0] m;
      logic [7:0] mask;
      int n, k, p;
      bq.delete();
      m = a & w;
      n = $countones(m);
      k = 0;
      if (n == 0) bq.push_back({4'd0, 4'd0, 4'd0, 1'b1, 1'b1});
      for (int s = 0; s < 8; s++) begin
         p = msb ? 7 - s : s;
         if (m[p]) begin
            mask = 8'hFF;
            if (msb) mask = mask << (p + 1);
            else     mask = ~(mask << p);
            k++;
            bq.push_back({4'(p), 4'($countones(a & mask)),
                          4'($countones(w & mask)), (k == n), 1'b0});
         end
      end
   endfunction

   bit    m_busy = 1'b0;
   bit    m_ov = 1'b0;
   beat_t cur0, cur1;
   beat_t q0[$];
   beat_t q1[$];

   initial forever begin
      bit acc, free;
      @(posedge clk or negedge rst_n);
      if (!rst_n || flush) begin
         m_busy = 1'b0;
         m_ov   = 1'b0;
         q0.delete();
         q1.delete();
      end else begin
         acc  = !m_busy && in_vld;
         free = !m_ov || out_rdy;
         if (m_busy && free) begin
            cur0 = q0.pop_front();
            cur1 = q1.pop_front();
            m_ov = 1'b1;
            if (q0.size() == 0) m_busy = 1'b0;
         end else if (free) begin
            m_ov = 1'b0;
         end
         if (acc) begin
            build(act, wei, 1'b0);
            q0 = bq;
            build(act, wei, 1'b1);
            q1 = bq;
            m_busy = 1'b1;
         end
      end
   end

   initial forever begin
      logic exp_rdy;
      @(negedge clk);
      exp_rdy = rst_n && !m_busy && !flush;
      chk("cyc_rdy_lsb", ifl.in_rdy, exp_rdy);
      chk("cyc_rdy_msb", ifm.in_rdy, exp_rdy);
      chk("cyc_vld_lsb", ifl.out_vld, m_ov);
      chk("cyc_vld_msb", ifm.out_vld, m_ov);
      if (rst_n && m_ov) begin
         chk("cyc_beat_lsb", beat_l(), cur0);
         chk("cyc_beat_msb", beat_m(), cur1);
      end
      if (!rst_n) begin
         chk("cyc_rst_lsb", beat_l(), '0);
         chk("cyc_rst_msb", beat_m(), '0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] w);
      bit ok;
      int n;
      ok = 1'b0;
      n  = 0;
      act = a;
      wei = w;
      in_vld = 1'b1;
      do begin
         @(negedge clk);
         ok = ifl.in_rdy;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      in_vld = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout got=in_rdy_low exp=accept");
      end
   endtask

   initial begin
      build(8'h0B, 8'h06, 1'b0);
      chk("pin_0b06_n", bq.size(), 1);
      chk("pin_0b06", bq[0], {4'd1, 4'd1, 4'd0, 1'b1, 1'b0});
      build(8'hFF, 8'hFF, 1'b0);
      chk("pin_ff_n", bq.size(), 8);
      chk("pin_ff_6", bq[6], {4'd6, 4'd6, 4'd6, 1'b0, 1'b0});
      chk("pin_ff_7", bq[7], {4'd7, 4'd7, 4'd7, 1'b1, 1'b0});
      build(8'h81, 8'h81, 1'b1);
      chk("pin_81_0", bq[0], {4'd7, 4'd0, 4'd0, 1'b0, 1'b0});
      chk("pin_81_1", bq[1], {4'd0, 4'd1, 4'd1, 1'b1, 1'b0});
      build(8'hF0, 8'h0F, 1'b0);
      chk("pin_empty", bq[0], {4'd0, 4'd0, 4'd0, 1'b1, 1'b1});

      repeat (2) step();
      chk("rst_vld", ifl.out_vld, 1'b0);
      chk("rst_rdy", ifl.in_rdy, 1'b0);
      chk("rst_beat", beat_l(), '0);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_rdy", ifl.in_rdy, 1'b1);

      out_rdy = 1'b1;
      send(8'h0B, 8'h06);
      step();
      chk("t1_vld", ifl.out_vld, 1'b1);
      chk("t1_lsb", beat_l(), {4'd1, 4'd1, 4'd0, 1'b1, 1'b0});
      chk("t1_msb", beat_m(), {4'd1, 4'd1, 4'd1, 1'b1, 1'b0});
      step();

      send(8'hFF, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("ff_lsb", beat_l(), {4'(i), 4'(i), 4'(i), (i == 7), 1'b0});
         chk("ff_msb", beat_m(), {4'(7 - i), 4'(i), 4'(i), (i == 7), 1'b0});
      end
      step();

      send(8'h81, 8'h81);
      step();
      chk("m81_0", beat_m(), {4'd7, 4'd0, 4'd0, 1'b0, 1'b0});
      step();
      chk("m81_1", beat_m(), {4'd0, 4'd1, 4'd1, 1'b1, 1'b0});
      step();

      send(8'hF0, 8'h0F);
      step();
      chk("emp_beat", beat_l(), {4'd0, 4'd0, 4'd0, 1'b1, 1'b1});
      chk("emp_vld", ifl.out_vld, 1'b1);
      chk("emp_rdy", ifl.in_rdy, 1'b1);
      step();

      out_rdy = 1'b0;
      send(8'h05, 8'h05);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold", beat_l(), {4'd0, 4'd0, 4'd0, 1'b0, 1'b0});
         chk("bp_vld", ifl.out_vld, 1'b1);
         if (i < 2) step();
      end
      out_rdy = 1'b1;
      step();
      chk("bp_2", beat_l(), {4'd2, 4'd1, 4'd1, 1'b1, 1'b0});
      step();

      send(8'hFF, 8'hFF);
      repeat (4) step();
      chk("fl_b3", beat_l(), {4'd3, 4'd3, 4'd3, 1'b0, 1'b0});
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("fl_vld", ifl.out_vld, 1'b0);
      chk("fl_rdy", ifl.in_rdy, 1'b1);
      step();

      send(8'hFF, 8'hFF);
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      chk("mr_vld", ifl.out_vld, 1'b0);
      chk("mr_rdy", ifl.in_rdy, 1'b0);
      chk("mr_lsb", beat_l(), '0);
      chk("mr_msb", beat_m(), '0);
      step();
      rst_n = 1'b1;

      repeat (1500) begin
         int mode;
         step();
         mode = $urandom_range(0, 5);
         in_vld = ($urandom_range(0, 9) < 7);
         act = 8'($urandom);
         wei = 8'($urandom);
         if (mode == 1) wei = act;
         if (mode == 2) begin act = 8'hFF; wei = 8'hFF; end
         if (mode == 3) wei = ~act;
         if (mode == 4) wei = wei & 8'($urandom);
         out_rdy = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 49) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
      end

      flush = 1'b0;
      rst_n = 1'b1;
      in_vld = 1'b0;
      out_rdy = 1'b1;
      repeat (20) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
